// File: rtl/logic_gates_dataflow_model_design.sv
// Bitwise two-input gate unit: AND, NAND, OR, NOR, NOT(a), XOR and XNOR of a/b
// computed in parallel. REG_OUT selects one-cycle registered outputs or a
// purely combinational path; in_valid only travels alongside as out_valid.
module logic_gates_dataflow_model_design #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] yand,
  output logic [WIDTH-1:0] ynand,
  output logic [WIDTH-1:0] yor,
  output logic [WIDTH-1:0] ynor,
  output logic [WIDTH-1:0] ynot,
  output logic [WIDTH-1:0] yxor,
  output logic [WIDTH-1:0] yxnor,
  output logic             out_valid
);

  // Gate functions, strictly per bit position: no carry, no cross-bit terms,
  // so an X on one input bit only reaches the result bits at that position.
  logic [WIDTH-1:0] and_c;
  logic [WIDTH-1:0] nand_c;
  logic [WIDTH-1:0] or_c;
  logic [WIDTH-1:0] nor_c;
  logic [WIDTH-1:0] not_c;
  logic [WIDTH-1:0] xor_c;
  logic [WIDTH-1:0] xnor_c;

  assign and_c  = a & b;
  assign nand_c = ~(a & b);
  assign or_c   = a | b;
  assign nor_c  = ~(a | b);
  assign not_c  = ~a;
  assign xor_c  = a ^ b;
  assign xnor_c = ~(a ^ b);

  generate
    if (REG_OUT) begin : g_reg
      // Result and valid registers; the results load every cycle regardless of
      // in_valid, and reset clears all of them (complemented outputs included).
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values of its sources, independent of statement order.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          yand      <= '0;
          ynand     <= '0;
          yor       <= '0;
          ynor      <= '0;
          ynot      <= '0;
          yxor      <= '0;
          yxnor     <= '0;
          out_valid <= 1'b0;
        end else begin
          yand      <= and_c;
          ynand     <= nand_c;
          yor       <= or_c;
          ynor      <= nor_c;
          ynot      <= not_c;
          yxor      <= xor_c;
          yxnor     <= xnor_c;
          out_valid <= in_valid;
        end
      end
    end else begin : g_comb
      // Zero-latency variant: clk and rst are present only for port
      // compatibility; outputs track the inputs continuously.
      assign yand      = and_c;
      assign ynand     = nand_c;
      assign yor       = or_c;
      assign ynor      = nor_c;
      assign ynot      = not_c;
      assign yxor      = xor_c;
      assign yxnor     = xnor_c;
      assign out_valid = in_valid;
    end
  endgenerate

endmodule

// File: tb/tb_logic_gates_dataflow_model_design.sv
// Directed bench for the gate unit: truth table (registered and combinational),
// async reset, 8-bit vector, valid pipeline and a 16-bit random sweep with
// invariant checks.
module tb_logic_gates_dataflow_model_design;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv  = 1'b0;

  logic        a1 = 1'b0, b1 = 1'b0;
  logic [7:0]  a8 = '0,   b8 = '0;
  logic [15:0] a16 = '0,  b16 = '0;

  logic        r1_and, r1_nand, r1_or, r1_nor, r1_not, r1_xor, r1_xnor, r1_ov;
  logic        c1_and, c1_nand, c1_or, c1_nor, c1_not, c1_xor, c1_xnor, c1_ov;
  logic [7:0]  r8_and, r8_nand, r8_or, r8_nor, r8_not, r8_xor, r8_xnor;
  logic        r8_ov;
  logic [15:0] r16_and, r16_nand, r16_or, r16_nor, r16_not, r16_xor, r16_xnor;
  logic        r16_ov;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  logic_gates_dataflow_model_design #(.WIDTH(1), .REG_OUT(1'b1)) u_r1 (
    .clk(clk), .rst(rst), .in_valid(iv), .a(a1), .b(b1),
    .yand(r1_and), .ynand(r1_nand), .yor(r1_or), .ynor(r1_nor), .ynot(r1_not),
    .yxor(r1_xor), .yxnor(r1_xnor), .out_valid(r1_ov));

  logic_gates_dataflow_model_design #(.WIDTH(1), .REG_OUT(1'b0)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(iv), .a(a1), .b(b1),
    .yand(c1_and), .ynand(c1_nand), .yor(c1_or), .ynor(c1_nor), .ynot(c1_not),
    .yxor(c1_xor), .yxnor(c1_xnor), .out_valid(c1_ov));

  logic_gates_dataflow_model_design #(.WIDTH(8), .REG_OUT(1'b1)) u_r8 (
    .clk(clk), .rst(rst), .in_valid(iv), .a(a8), .b(b8),
    .yand(r8_and), .ynand(r8_nand), .yor(r8_or), .ynor(r8_nor), .ynot(r8_not),
    .yxor(r8_xor), .yxnor(r8_xnor), .out_valid(r8_ov));

  logic_gates_dataflow_model_design #(.WIDTH(16), .REG_OUT(1'b1)) u_r16 (
    .clk(clk), .rst(rst), .in_valid(iv), .a(a16), .b(b16),
    .yand(r16_and), .ynand(r16_nand), .yor(r16_or), .ynor(r16_nor), .ynot(r16_not),
    .yxor(r16_xor), .yxnor(r16_xnor), .out_valid(r16_ov));

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed truth-table columns, bit i = vector i (a,b = 00,01,10,11).
  logic [3:0] t_and  = 4'b1000;
  logic [3:0] t_nand = 4'b0111;
  logic [3:0] t_or   = 4'b1110;
  logic [3:0] t_nor  = 4'b0001;
  logic [3:0] t_not  = 4'b0011;
  logic [3:0] t_xor  = 4'b0110;
  logic [3:0] t_xnor = 4'b1001;
  logic [3:0] v_pat  = 4'b1101;   // in_valid pattern 1,0,1,1 (bit 0 first)
  logic [15:0] ea, eb;

  initial begin
    // Reset state (rst high from time 0).
    #2;
    check("rst_and",  r1_and,  0); check("rst_nand", r1_nand, 0);
    check("rst_nor",  r1_nor,  0); check("rst_not",  r1_not,  0);
    check("rst_xnor", r1_xnor, 0); check("rst_ov",   r1_ov,   0);
    check("rst_comb_nand", c1_nand, 1);   // combinational variant ignores reset
    tick();
    rst = 1'b0;
    iv  = 1'b1;

    // Truth table: combinational checked in-cycle, registered one edge later.
    for (int i = 0; i < 4; i++) begin
      a1 = i[1]; b1 = i[0];
      #1;
      check("c_and",  c1_and,  t_and[i]);  check("c_nand", c1_nand, t_nand[i]);
      check("c_or",   c1_or,   t_or[i]);   check("c_nor",  c1_nor,  t_nor[i]);
      check("c_not",  c1_not,  t_not[i]);  check("c_xor",  c1_xor,  t_xor[i]);
      check("c_xnor", c1_xnor, t_xnor[i]); check("c_ov",   c1_ov,   1);
      tick();
      check("r_and",  r1_and,  t_and[i]);  check("r_nand", r1_nand, t_nand[i]);
      check("r_or",   r1_or,   t_or[i]);   check("r_nor",  r1_nor,  t_nor[i]);
      check("r_not",  r1_not,  t_not[i]);  check("r_xor",  r1_xor,  t_xor[i]);
      check("r_xnor", r1_xnor, t_xnor[i]); check("r_ov",   r1_ov,   1);
    end

    // Async reset between edges.
    a1 = 1'b1; b1 = 1'b0;
    tick();
    check("pre_rst_or", r1_or, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_or",   r1_or,   0); check("arst_xor",  r1_xor,  0);
    check("arst_nand", r1_nand, 0); check("arst_nor",  r1_nor,  0);
    check("arst_not",  r1_not,  0); check("arst_xnor", r1_xnor, 0);
    check("arst_ov",   r1_ov,   0);
    check("arst_comb_or", c1_or, 1);
    #1 rst = 1'b0;
    #1;
    check("held_or", r1_or, 0);       // no edge yet: still cleared
    tick();
    check("rec_or", r1_or, 1); check("rec_xor", r1_xor, 1); check("rec_not", r1_not, 0);

    // 8-bit vector.
    a8 = 8'hF0; b8 = 8'hCC;
    tick();
    check("w8_and",  r8_and,  8'hC0); check("w8_nand", r8_nand, 8'h3F);
    check("w8_or",   r8_or,   8'hFC); check("w8_nor",  r8_nor,  8'h03);
    check("w8_not",  r8_not,  8'h0F); check("w8_xor",  r8_xor,  8'h3C);
    check("w8_xnor", r8_xnor, 8'hC3);

    // Valid pipeline 1,0,1,1; operands change every cycle, results must follow.
    for (int i = 0; i < 4; i++) begin
      iv = v_pat[i];
      a8 = 8'h11 * i[7:0]; b8 = 8'hA5;
      tick();
      check("vp_ov",  r8_ov,  v_pat[i]);
      check("vp_xor", r8_xor, (8'h11 * i[7:0]) ^ 8'hA5);
      check("vp_and", r8_and, (8'h11 * i[7:0]) & 8'hA5);
    end
    iv = 1'b1;

    // Random 16-bit sweep with invariants.
    for (int n = 0; n < 1000; n++) begin
      ea = 16'($urandom); eb = 16'($urandom);
      a16 = ea; b16 = eb;
      tick();
      check("rnd_and",  r16_and,  ea & eb);
      check("rnd_nand", r16_nand, ~(ea & eb));
      check("rnd_or",   r16_or,   ea | eb);
      check("rnd_nor",  r16_nor,  ~(ea | eb));
      check("rnd_not",  r16_not,  ~ea);
      check("rnd_xor",  r16_xor,  ea ^ eb);
      check("rnd_xnor", r16_xnor, ~(ea ^ eb));
      check("inv_nand", r16_nand, ~r16_and);
      check("inv_nor",  r16_nor,  ~r16_or);
      check("inv_xnor", r16_xnor, ~r16_xor);
      check("inv_xor",  r16_xor,  r16_or & r16_nand);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
